// File: rtl/btn_pkg.sv
// Shared types and default timing parameters for the button press classifier.
package btn_pkg;

    localparam int TICK_DIV_DEF     = 100000;
    localparam int LONG_TICKS_DEF   = 1000;
    localparam int DCLICK_TICKS_DEF = 300;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_LONG   = 3'd3,
        ST_PRESS2 = 3'd4
    } btn_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running timebase: tick is high for one clk at the terminal count.
module tick_gen
    import btn_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (cnt == TERM)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button into short, long and double-click gestures.
module press_classifier
    import btn_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int DCLICK_TICKS = DCLICK_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic db_in,
    output logic short_p,
    output logic long_p,
    output logic dbl_p,
    output logic held
);

    localparam int CNT_W = $clog2(max2(LONG_TICKS, DCLICK_TICKS) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] DCLK_CNT = CNT_W'(DCLICK_TICKS);

    btn_state_t     state, state_nx;
    logic           db_prev, rise, fall, tick;
    logic [CNT_W-1:0] cnt;
    logic           short_nx, long_nx, dbl_nx;
    logic           short_f, long_f, dbl_f;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rise = db_in & ~db_prev;
    assign fall = ~db_in & db_prev;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        short_nx = 1'b0;
        long_nx  = 1'b0;
        dbl_nx   = 1'b0;
        case (state)
            ST_IDLE:   if (rise) state_nx = ST_PRESS1;
            ST_PRESS1: begin
                // A release on the same cycle as the long threshold counts as a short press.
                if (fall) begin
                    state_nx = ST_GAP;
                end else if (cnt == LONG_CNT) begin
                    state_nx = ST_LONG;
                    long_nx  = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_nx = ST_PRESS2;
                    dbl_nx   = 1'b1;
                end else if (cnt == DCLK_CNT) begin
                    state_nx = ST_IDLE;
                    short_nx = 1'b1;
                end
            end
            ST_LONG:   if (fall) state_nx = ST_IDLE;
            ST_PRESS2: if (fall) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            db_prev <= 1'b0;
        end else begin
            state   <= state_nx;
            db_prev <= db_in;
        end
    end

    // Interval restarts on every state change and saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state_nx != state)
            cnt <= '0;
        else if (tick && (cnt != CNT_MAX))
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            short_f <= 1'b0;
            long_f  <= 1'b0;
            dbl_f   <= 1'b0;
            short_p <= 1'b0;
            long_p  <= 1'b0;
            dbl_p   <= 1'b0;
            held    <= 1'b0;
        end else begin
            short_f <= short_nx;
            long_f  <= long_nx;
            dbl_f   <= dbl_nx;
            short_p <= short_f;
            long_p  <= long_f;
            dbl_p   <= dbl_f;
            held    <= (state == ST_LONG);
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench: gesture table, timing corner sequences and random presses vs a reference model.
module tb_press_classifier;

    localparam int TD = 4;
    localparam int LT = 5;
    localparam int DT = 3;

    // Reference model gesture phases
    localparam int M_REST  = 0;
    localparam int M_DOWN  = 1;
    localparam int M_WAIT  = 2;
    localparam int M_HOLD  = 3;
    localparam int M_DOWN2 = 4;

    logic clk = 1'b0;
    logic reset;
    logic db_in;
    logic short_p, long_p, dbl_p, held;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cnt_s, cnt_l, cnt_d;

    int       m_prev, m_phase, m_mode, m_elapsed;
    logic [2:0] m_flag, m_out;   // {short, long, dbl}
    logic     m_held;

    typedef struct {
        int hi1;
        int lo1;
        int hi2;
        int exp_s;
        int exp_l;
        int exp_d;
    } vec_t;

    vec_t vecs[6];

    press_classifier #(
        .TICK_DIV     (TD),
        .LONG_TICKS   (LT),
        .DCLICK_TICKS (DT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .db_in   (db_in),
        .short_p (short_p),
        .long_p  (long_p),
        .dbl_p   (dbl_p),
        .held    (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev    = 0;
        m_phase   = 0;
        m_mode    = M_REST;
        m_elapsed = 0;
        m_flag    = 3'b000;
        m_out     = 3'b000;
        m_held    = 1'b0;
    endtask

    // One clock of gesture behaviour: decide the outcome, then delay pulses two cycles.
    task automatic model_edge();
        bit rise, fall, tk, ps, pl, pd;
        int nm;
        rise = (db_in == 1'b1) && (m_prev == 0);
        fall = (db_in == 1'b0) && (m_prev == 1);
        tk   = (m_phase == TD - 1);
        nm   = m_mode;
        ps = 0; pl = 0; pd = 0;
        case (m_mode)
            M_REST:  if (rise) nm = M_DOWN;
            M_DOWN:  if (fall) nm = M_WAIT;
                     else if (m_elapsed >= LT) begin nm = M_HOLD; pl = 1; end
            M_WAIT:  if (rise) begin nm = M_DOWN2; pd = 1; end
                     else if (m_elapsed >= DT) begin nm = M_REST; ps = 1; end
            M_HOLD:  if (fall) nm = M_REST;
            default: if (fall) nm = M_REST;
        endcase
        m_out     = m_flag;
        m_flag    = {ps, pl, pd};
        m_held    = (m_mode == M_HOLD);
        m_elapsed = (nm != m_mode) ? 0 : m_elapsed + int'(tk);
        m_mode    = nm;
        m_prev    = int'(db_in);
        m_phase   = (m_phase + 1) % TD;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_edge();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs_vs_model", 32'({short_p, long_p, dbl_p, held}), 32'({m_out, m_held}));
            check("pulse_onehot", 32'($onehot0({short_p, long_p, dbl_p})), 32'd1);
            cnt_s += int'(short_p);
            cnt_l += int'(long_p);
            cnt_d += int'(dbl_p);
        end
    end

    // Called at posedge+1; applies level v for n clock edges and returns at posedge+1.
    task automatic drive(input logic v, input int n);
        db_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cnt_s = 0;
        cnt_l = 0;
        cnt_d = 0;
    endtask

    // which: 0 short, 1 long, 2 dbl; lat = clock edges until pulse seen, -1 if budget expired.
    task automatic wait_pulse(input int which, input int budget, output int lat);
        logic [2:0] o;
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            @(negedge clk);
            o = {short_p, long_p, dbl_p};
            if (o[2 - which]) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_model(input int mode, input int elapsed, input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (m_mode == mode && m_elapsed == elapsed) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit found;

        vecs[0] = '{8,  40, 0,  1, 0, 0};
        vecs[1] = '{40, 40, 0,  0, 1, 0};
        vecs[2] = '{8,  6,  8,  0, 0, 1};
        vecs[3] = '{8,  20, 8,  2, 0, 0};
        vecs[4] = '{8,  6,  40, 0, 0, 1};
        vecs[5] = '{1,  40, 0,  1, 0, 0};

        reset = 1'b1;
        db_in = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_outputs", 32'({short_p, long_p, dbl_p, held}), 32'd0);
        reset = 1'b0;
        drive(1'b0, 5);

        for (int i = 0; i < 6; i++) begin
            clear_counts();
            drive(1'b1, vecs[i].hi1);
            drive(1'b0, vecs[i].lo1);
            if (vecs[i].hi2 > 0) begin
                drive(1'b1, vecs[i].hi2);
                drive(1'b0, 40);
            end
            check($sformatf("vec%0d_short_count", i), 32'(cnt_s), 32'(vecs[i].exp_s));
            check($sformatf("vec%0d_long_count", i),  32'(cnt_l), 32'(vecs[i].exp_l));
            check($sformatf("vec%0d_dbl_count", i),   32'(cnt_d), 32'(vecs[i].exp_d));
        end

        // Short press: short_p arrives 12-16 clk after the fall.
        drive(1'b1, 8);
        db_in = 1'b0;
        wait_pulse(0, 40, lat);
        check("short_latency_in_window", 32'(lat >= 12 && lat <= 16), 32'd1);
        drive(1'b0, 20);

        // Long press: long_p 20-24 clk after the rise, held drops 2 clk after the fall.
        clear_counts();
        db_in = 1'b1;
        wait_pulse(1, 40, lat);
        check("long_latency_in_window", 32'(lat >= 20 && lat <= 24), 32'd1);
        drive(1'b1, 10);
        db_in = 1'b0;
        @(negedge clk);
        check("held_at_fall", 32'(held), 32'd1);
        @(posedge clk); @(negedge clk);
        check("held_1clk_after_fall", 32'(held), 32'd1);
        @(posedge clk); @(negedge clk);
        check("held_2clk_after_fall", 32'(held), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 20);
        check("long_hold_no_short", 32'(cnt_s), 32'd0);
        check("long_hold_one_long", 32'(cnt_l), 32'd1);

        // Double click: dbl_p 2 clk after the second rise.
        clear_counts();
        drive(1'b1, 8);
        drive(1'b0, 6);
        db_in = 1'b1;
        wait_pulse(2, 10, lat);
        check("dbl_latency", 32'(lat), 32'd2);
        drive(1'b1, 5);
        drive(1'b0, 40);
        check("dbl_no_short", 32'(cnt_s), 32'd0);
        check("dbl_no_long", 32'(cnt_l), 32'd0);

        // Second rise exactly when the gap window is reached: double click wins.
        clear_counts();
        drive(1'b1, 8);
        db_in = 1'b0;
        wait_model(M_WAIT, DT, 40, found);
        check("gap_limit_reached", 32'(found), 32'd1);
        drive(1'b1, 8);
        drive(1'b0, 40);
        check("gap_tie_dbl", 32'(cnt_d), 32'd1);
        check("gap_tie_no_short", 32'(cnt_s), 32'd0);

        // Release exactly when the long threshold is reached: short press wins.
        clear_counts();
        db_in = 1'b1;
        wait_model(M_DOWN, LT, 60, found);
        check("press_limit_reached", 32'(found), 32'd1);
        drive(1'b0, 40);
        check("press_tie_no_long", 32'(cnt_l), 32'd0);
        check("press_tie_short", 32'(cnt_s), 32'd1);

        // Reset mid-press with the button held through it.
        clear_counts();
        drive(1'b1, 8);
        reset = 1'b1;
        #1;
        check("reset_async_outputs", 32'({short_p, long_p, dbl_p, held}), 32'd0);
        #1;
        drive(1'b1, 2);
        check("reset_held_outputs", 32'({short_p, long_p, dbl_p, held}), 32'd0);
        reset = 1'b0;
        drive(1'b1, 40);
        drive(1'b0, 20);
        check("post_reset_long", 32'(cnt_l), 32'd1);
        check("post_reset_no_short", 32'(cnt_s), 32'd0);

        // Random gestures with occasional resets, compared cycle by cycle against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                drive(db_in, $urandom_range(1, 3));
                reset = 1'b0;
            end
            drive(1'b1, $urandom_range(1, 30));
            drive(1'b0, $urandom_range(1, 20));
        end
        drive(1'b0, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
